dac_spi_ctrl: RTL

- Synthesizable SPI master for the LTC2624/LTC2604 quad DAC family. It replaces hand-driven bench sequences with an RTL controller.
- Issues the power-up DAC_CLR pulse, then accepts write requests over a valid/ready handshake.
- Serialises each request as a 32-bit frame on SPI_SCK/SPI_MOSI/DAC_CS.
- Sits between application logic and the board DAC pins, and optionally verifies the DAC's SDO echo.

---
 rtl/dac_spi_ctrl_if.sv | 12 +
 rtl/dac_spi_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_ctrl_if.sv
// Write-request handshake between application logic and dac_spi_ctrl.
interface dac_spi_ctrl_if #(
  parameter int DATA_W = 12
);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [3:0]        REQ_ADDR;
  logic [DATA_W-1:0] REQ_DATA;

  modport master (output REQ_VALID, REQ_ADDR, REQ_DATA, input REQ_READY);
  modport slave  (input REQ_VALID, REQ_ADDR, REQ_DATA, output REQ_READY);
endinterface

// File: rtl/dac_spi_ctrl.sv
// SPI master for LTC2624/LTC2604: power-up DAC_CLR, then 32-bit write frames.
// Define DAC_SPI_READBACK_EN to check the SDO echo against the previous frame.
module dac_spi_ctrl #(
  parameter int         DATA_W     = 12,
  parameter int         SCK_DIV    = 2,
  parameter int         CLR_CYCLES = 4,
  parameter int         CS_GAP     = 2,
  parameter logic [3:0] CMD        = 4'b0011
) (
  input  logic           CLK,
  input  logic           RST_N,
  dac_spi_ctrl_if.slave  req,
  input  logic           SOFT_CLR,
  output logic           BUSY,
  output logic           DONE,
  output logic           ERR_ADDR,
  output logic           RB_ERR,
  output logic           SPI_SCK,
  output logic           SPI_MOSI,
  output logic           DAC_CS,
  output logic           DAC_CLR,
  input  logic           DAC_OUT
);

  typedef enum logic [2:0] {S_CLR, S_CLR_REC, S_IDLE, S_SETUP, S_SHIFT, S_GAP} state_t;

  localparam logic [15:0] CLR_LAST = 16'(CLR_CYCLES);
  localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);
  localparam logic [15:0] DIV_LAST = 16'(SCK_DIV - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [5:0]  bit_cnt;
  logic [30:0] shreg;
  logic        clr_pending;

  logic        addr_ok;
  logic [15:0] data16;
  logic [31:0] frame_in;

  assign req.REQ_READY = (state == S_IDLE) & ~SOFT_CLR;
  assign BUSY          = (state != S_IDLE);
  assign addr_ok       = (req.REQ_ADDR <= 4'd3) || (req.REQ_ADDR == 4'hF);
  // 12-bit samples are left-justified in the 16-bit data field
  assign data16        = 16'(req.REQ_DATA) << (16 - DATA_W);
  assign frame_in      = {8'h00, CMD, req.REQ_ADDR, data16};

`ifdef DAC_SPI_READBACK_EN
  logic [31:0] tx_frame;
  logic [31:0] prev_frame;
  logic [31:0] cap;
`else
  logic unused_dac_out;
  assign unused_dac_out = DAC_OUT;
  assign RB_ERR         = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_CLR;
      cnt         <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      clr_pending <= 1'b0;
      DAC_CS      <= 1'b1;
      SPI_SCK     <= 1'b0;
      SPI_MOSI    <= 1'b0;
      DAC_CLR     <= 1'b1;
      DONE        <= 1'b0;
      ERR_ADDR    <= 1'b0;
`ifdef DAC_SPI_READBACK_EN
      tx_frame    <= '0;
      prev_frame  <= '0;
      cap         <= '0;
      RB_ERR      <= 1'b0;
`endif
    end else begin
      DONE     <= 1'b0;
      ERR_ADDR <= 1'b0;
`ifdef DAC_SPI_READBACK_EN
      RB_ERR   <= 1'b0;
`endif
      if (SOFT_CLR && state != S_IDLE) clr_pending <= 1'b1;

      case (state)
        // from reset cnt starts at 0 with DAC_CLR high; explicit entries preload cnt=1
        S_CLR: begin
          if (cnt == CLR_LAST) begin
            DAC_CLR <= 1'b1;
            cnt     <= '0;
            state   <= S_CLR_REC;
          end else begin
            DAC_CLR <= 1'b0;
            cnt     <= cnt + 16'd1;
          end
        end

        S_CLR_REC: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_IDLE: begin
          if (SOFT_CLR) begin
            state       <= S_CLR;
            DAC_CLR     <= 1'b0;
            cnt         <= 16'd1;
            clr_pending <= 1'b0;
`ifdef DAC_SPI_READBACK_EN
            prev_frame  <= '0;
`endif
          end else if (req.REQ_VALID) begin
            if (addr_ok) begin
              shreg    <= frame_in[30:0];
              SPI_MOSI <= frame_in[31];
              DAC_CS   <= 1'b0;
              cnt      <= '0;
              bit_cnt  <= '0;
              state    <= S_SETUP;
`ifdef DAC_SPI_READBACK_EN
              tx_frame <= frame_in;
`endif
            end else begin
              ERR_ADDR <= 1'b1;
            end
          end
        end

        S_SETUP: begin
          if (cnt == DIV_LAST) begin
            SPI_SCK <= 1'b1;
            cnt     <= '0;
            state   <= S_SHIFT;
`ifdef DAC_SPI_READBACK_EN
            cap     <= {cap[30:0], DAC_OUT};
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        S_SHIFT: begin
          if (SPI_SCK) begin
            if (cnt == DIV_LAST) begin
              SPI_SCK <= 1'b0;
              cnt     <= '0;
              bit_cnt <= bit_cnt + 6'd1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else begin
            // next bit one CLK after the falling edge; zeros shift in after bit 0
            if (cnt == '0) begin
              SPI_MOSI <= shreg[30];
              shreg    <= {shreg[29:0], 1'b0};
            end
            if (cnt == DIV_LAST) begin
              cnt <= '0;
              if (bit_cnt == 6'd32) begin
                DAC_CS <= 1'b1;
                DONE   <= 1'b1;
                state  <= S_GAP;
`ifdef DAC_SPI_READBACK_EN
                RB_ERR     <= (cap != prev_frame);
                prev_frame <= tx_frame;
`endif
              end else begin
                SPI_SCK <= 1'b1;
`ifdef DAC_SPI_READBACK_EN
                cap     <= {cap[30:0], DAC_OUT};
`endif
              end
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end

        S_GAP: begin
          if (cnt == GAP_LAST) begin
            // a SOFT_CLR arriving on the final gap cycle is honoured here too
            if (clr_pending || SOFT_CLR) begin
              state       <= S_CLR;
              DAC_CLR     <= 1'b0;
              cnt         <= 16'd1;
              clr_pending <= 1'b0;
`ifdef DAC_SPI_READBACK_EN
              prev_frame  <= '0;
`endif
            end else begin
              cnt   <= '0;
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: state <= S_CLR;
      endcase
    end
  end

endmodule
